peripheral_putresult: RTL and testbench
=======================================

Name: peripheral_putresult

Overview:
- Result-readout peripheral. Captures the 32-bit ALU result dataR through a valid/ready handshake.
- Presents the result one byte at a time on the 8-bit LED/display bus. It is the output counterpart of the operand-entry block, which writes bytes in.
- Byte index advances on each press of the enter button, or automatically on a timer when autoscroll is set.
- Sits between the arithmetic core and the board LEDs/7-segment driver.

Parameters:
- NBYTES, 4, number of bytes presented per result. dataR width is NBYTES*8.
- SCROLL_CYCLES, 50000000, clk cycles per byte in autoscroll mode. Must be ≥2. Timer width is $clog2(SCROLL_CYCLES).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- dataR  input  32  result word from arithmetic core
- result_valid  input  1  dataR is valid this cycle
- result_ready  output  1  block accepts a new result this cycle
- enterpulse  input  1  debounced enter button level, advance on rising edge
- autoscroll  input  1  1 = timer-driven advance, enter still works
- dataoutput  output  8  byte currently presented
- bytepos  output  2  index of byte on dataoutput, 0 = dataR[7:0]
- busy  output  1  a result is being presented
- done  output  1  one-cycle pulse after the last byte is dismissed

Behaviour:
- One clock; reset is synchronous and active-high. All state changes on posedge clk. reset has priority over every other event.
- Reset values:
  - state IDLE, shadow register 0, bytepos 0, dataoutput 8'h00
  - busy 0, done 0, enter_q 0, timer 0
  - result_ready reads 1 once reset deasserts (it decodes IDLE)
- Edge detect: step = enterpulse & ~enter_q, with enter_q <= enterpulse every cycle. A held button gives exactly one step.
- result_ready = (state == IDLE). This is combinational from state, so there is no combinational path from result_valid.
- States:
  - IDLE:
    - busy=0. dataoutput keeps the last byte shown (0 after reset). step is ignored.
    - When result_valid & result_ready: shadow <= dataR, bytepos <= 0, timer <= 0, state <= SHOW.
  - SHOW:
    - busy=1, result_ready=0. dataoutput = shadow[8*bytepos +: 8], registered. byte0 appears the cycle after acceptance (1-cycle latency).
    - Advance condition: adv = step | (autoscroll & timer == SCROLL_CYCLES-1).
    - Timer increments each cycle while autoscroll=1. It clears on adv, on entering SHOW, and whenever autoscroll=0.
    - On adv with bytepos < NBYTES-1: bytepos <= bytepos+1. The new byte shows next cycle.
    - On adv with bytepos == NBYTES-1: state <= DONE. bytepos and dataoutput hold.
  - DONE:
    - done=1 and busy=0 for exactly one cycle, then state <= IDLE.
    - result_valid in DONE is not accepted (result_ready=0).
- Boundary conditions:
  - step and timer expiry in the same cycle: a single advance, never two.
  - result_valid while SHOW/DONE: ignored, and the shadow is unchanged. The producer must hold valid until ready.
  - dataR changing during SHOW does not affect the displayed bytes (shadow copy).
  - bytepos never exceeds NBYTES-1 and never wraps mid-result.
  - reset mid-SHOW: next cycle is IDLE with all reset values. The partial presentation is discarded and done is not pulsed.
  - Toggling autoscroll mid-SHOW restarts the timer from 0.

Test Plan:
- Reset, then result_valid=1 with dataR=32'hDEADBEEF. Expected: result_ready=1 before acceptance and 0 after. Next cycle dataoutput=8'hEF, bytepos=0, busy=1.
- Continuing, four enter presses, each held 5 cycles. Expected: dataoutput goes EF→BE→AD→DE with bytepos 0→3. The 4th press gives done=1 for exactly one cycle, then busy=0, result_ready=1, dataoutput stays 8'hDE.
- SCROLL_CYCLES=8, autoscroll=1, accept 32'h12345678 with no presses. Expected: the byte changes every 8 cycles (78,56,34,12), then done pulses 8 cycles after 8'h12 first appears.
- SCROLL_CYCLES=8, autoscroll=1, enter rising edge on the same cycle the timer hits 7. Expected: bytepos advances by exactly 1 and the timer restarts at 0.
- During SHOW, drive result_valid=1 with dataR=32'hCAFEF00D. Expected: not accepted, result_ready stays 0, and the displayed bytes still come from the first result.
- Assert reset for one cycle while bytepos=2. Expected: next cycle state IDLE, dataoutput=8'h00, bytepos=0, busy=0, done never pulses, result_ready=1.

Source files
------------

// File: rtl/peripheral_putresult.sv
// peripheral_putresult: captures a result word over valid/ready and shows it
// one byte at a time, advanced by the enter button or by an autoscroll timer.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   dataR             result word from the arithmetic core (NBYTES*8 bits)
//   result_valid      dataR is valid this cycle
//   result_ready      high while idle, so a new result can be taken
//   enterpulse        debounced enter level; its rising edge advances
//   autoscroll        1 = advance every SCROLL_CYCLES cycles as well
//   dataoutput        byte currently presented
//   bytepos           index of the presented byte, 0 = dataR[7:0]
//   busy              a result is being presented
//   done              one-cycle pulse after the last byte is dismissed
module peripheral_putresult #(
    parameter int NBYTES        = 4,
    parameter int SCROLL_CYCLES = 50000000,
    localparam int BW = (NBYTES > 1) ? $clog2(NBYTES) : 1,
    localparam int TW = $clog2(SCROLL_CYCLES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NBYTES*8-1:0]   dataR,
    input  logic                  result_valid,
    output logic                  result_ready,
    input  logic                  enterpulse,
    input  logic                  autoscroll,
    output logic [7:0]            dataoutput,
    output logic [BW-1:0]         bytepos,
    output logic                  busy,
    output logic                  done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SHOW = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           state;
    logic [NBYTES*8-1:0]  shadow;
    logic                 enter_q;
    logic [TW-1:0]        timer;

    logic                 step;
    logic                 expire;
    logic                 adv;
    logic                 last;
    logic [BW-1:0]        pos_nxt;
    logic [7:0]           bytes [NBYTES];

    for (genvar i = 0; i < NBYTES; i++) begin : g_bytes
        assign bytes[i] = shadow[8*i +: 8];
    end

    assign step    = enterpulse & ~enter_q;
    assign expire  = autoscroll & (timer == TW'(SCROLL_CYCLES - 1));
    // Step and timer expiry together still make one advance.
    assign adv     = step | expire;
    assign last    = (bytepos == BW'(NBYTES - 1));
    assign pos_nxt = bytepos + 1'b1;

    // Ready decodes state only: no combinational path from result_valid.
    assign result_ready = (state == S_IDLE);
    assign busy         = (state == S_SHOW);
    assign done         = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            shadow     <= '0;
            bytepos    <= '0;
            dataoutput <= 8'h00;
            enter_q    <= 1'b0;
            timer      <= '0;
        end else begin
            enter_q <= enterpulse;
            unique case (state)
                S_IDLE: begin
                    timer <= '0;
                    if (result_valid) begin
                        shadow     <= dataR;
                        bytepos    <= '0;
                        dataoutput <= dataR[7:0];
                        state      <= S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (adv) begin
                        timer <= '0;
                        if (last) begin
                            // Last byte stays on the bus after dismissal.
                            state <= S_DONE;
                        end else begin
                            bytepos    <= pos_nxt;
                            dataoutput <= bytes[pos_nxt];
                        end
                    end else if (autoscroll) begin
                        timer <= timer + 1'b1;
                    end else begin
                        timer <= '0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_putresult.sv
// Testbench for peripheral_putresult: directed stimulus, a behavioural
// reference model checked every cycle, and hand-computed literal checks.
module tb_peripheral_putresult;

    localparam int SC = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] dataR = '0;
    logic        result_valid = 1'b0;
    logic        result_ready;
    logic        enterpulse = 1'b0;
    logic        autoscroll = 1'b0;
    logic [7:0]  dataoutput;
    logic [1:0]  bytepos;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;
    int done_seen = 0;

    peripheral_putresult #(.NBYTES(4), .SCROLL_CYCLES(SC)) dut (
        .clk(clk),
        .reset(reset),
        .dataR(dataR),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .enterpulse(enterpulse),
        .autoscroll(autoscroll),
        .dataoutput(dataoutput),
        .bytepos(bytepos),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what is on display, which byte of which word,
    // and how long the current byte has been shown.
    typedef enum int {M_IDLE, M_SHOW, M_DONE} mphase_t;
    mphase_t     m_phase = M_IDLE;
    logic [7:0]  m_word [4];
    int          m_idx = 0;
    int          m_age = 0;
    logic [7:0]  m_shown = 8'h00;
    logic        m_prev = 1'b0;

    always @(posedge clk) begin
        logic press;
        logic timeout;
        press  = enterpulse && !m_prev;
        m_prev = enterpulse;
        if (reset) begin
            m_phase = M_IDLE;
            m_idx   = 0;
            m_age   = 0;
            m_shown = 8'h00;
            m_prev  = 1'b0;
        end else begin
            case (m_phase)
                M_IDLE: if (result_valid) begin
                    for (int b = 0; b < 4; b++) m_word[b] = dataR[8*b +: 8];
                    m_idx   = 0;
                    m_age   = 0;
                    m_shown = m_word[0];
                    m_phase = M_SHOW;
                end
                M_SHOW: begin
                    timeout = autoscroll && (m_age == SC - 1);
                    if (press || timeout) begin
                        m_age = 0;
                        if (m_idx == 3) m_phase = M_DONE;
                        else begin
                            m_idx   = m_idx + 1;
                            m_shown = m_word[m_idx];
                        end
                    end else begin
                        m_age = autoscroll ? m_age + 1 : 0;
                    end
                end
                default: m_phase = M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        check("model_ready", 32'(result_ready), 32'(m_phase == M_IDLE));
        check("model_busy", 32'(busy), 32'(m_phase == M_SHOW));
        check("model_done", 32'(done), 32'(m_phase == M_DONE));
        check("model_bytepos", 32'(bytepos), 32'(m_idx));
        check("model_data", 32'(dataoutput), 32'(m_shown));
        if (done === 1'b1) done_seen++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic press_btn();
        enterpulse = 1'b1;
        tick(5);
        enterpulse = 1'b0;
        tick(2);
    endtask

    initial begin
        tick(2);
        reset = 1'b0;
        tick(1);
        check("rst_ready", 32'(result_ready), 32'd1);
        check("rst_data", 32'(dataoutput), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);

        // Manual stepping through DEADBEEF.
        dataR = 32'hDEADBEEF;
        result_valid = 1'b1;
        tick(1);
        result_valid = 1'b0;
        check("acc_ready", 32'(result_ready), 32'd0);
        check("acc_byte0", 32'(dataoutput), 32'hEF);
        check("acc_pos0", 32'(bytepos), 32'd0);
        check("acc_busy", 32'(busy), 32'd1);

        // A second result offered mid-presentation must be ignored.
        dataR = 32'hCAFEF00D;
        result_valid = 1'b1;
        press_btn();
        check("p1_byte", 32'(dataoutput), 32'hBE);
        check("p1_ready", 32'(result_ready), 32'd0);
        press_btn();
        check("p2_byte", 32'(dataoutput), 32'hAD);
        result_valid = 1'b0;
        press_btn();
        check("p3_byte", 32'(dataoutput), 32'hDE);
        check("p3_pos", 32'(bytepos), 32'd3);
        press_btn();
        check("p4_done_cnt", 32'(done_seen), 32'd1);
        check("p4_busy", 32'(busy), 32'd0);
        check("p4_ready", 32'(result_ready), 32'd1);
        check("p4_hold", 32'(dataoutput), 32'hDE);

        // Autoscroll through 12345678 with no presses.
        autoscroll = 1'b1;
        dataR = 32'h12345678;
        result_valid = 1'b1;
        tick(1);
        result_valid = 1'b0;
        check("as_b0", 32'(dataoutput), 32'h78);
        tick(7);
        check("as_b0_hold", 32'(dataoutput), 32'h78);
        tick(1);
        check("as_b1", 32'(dataoutput), 32'h56);
        tick(8);
        check("as_b2", 32'(dataoutput), 32'h34);
        tick(8);
        check("as_b3", 32'(dataoutput), 32'h12);
        tick(7);
        check("as_b3_busy", 32'(busy), 32'd1);
        tick(1);
        check("as_done", 32'(done), 32'd1);
        tick(1);
        check("as_idle", 32'(result_ready), 32'd1);
        check("as_done_cnt", 32'(done_seen), 32'd2);

        // Press coinciding with timer expiry, then reset at bytepos 2.
        dataR = 32'hAABBCCDD;
        result_valid = 1'b1;
        tick(1);
        result_valid = 1'b0;
        tick(7);
        enterpulse = 1'b1;
        tick(1);
        check("co_pos", 32'(bytepos), 32'd1);
        check("co_byte", 32'(dataoutput), 32'hCC);
        tick(7);
        check("co_restart", 32'(bytepos), 32'd1);
        enterpulse = 1'b0;
        tick(1);
        check("co_next", 32'(bytepos), 32'd2);
        check("co_next_byte", 32'(dataoutput), 32'hBB);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("mr_data", 32'(dataoutput), 32'h00);
        check("mr_pos", 32'(bytepos), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_ready", 32'(result_ready), 32'd1);
        tick(20);
        check("mr_no_done", 32'(done_seen), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
